vector_normalizer: RTL and testbench

VECTOR_NORMALIZER -- requirements
Module: vector_normalizer

---
 rtl/vector_normalizer.sv | 200 ++++++++++++++++++++
 tb/tb_vector_normalizer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vector_normalizer.sv
// Vector normaliser: o_data[k] = floor(x_k * 2^FRAC_BITS / floor(sqrt(sum x^2))).
// Multicycle datapath: square-accumulate, restoring square root, restoring divide.
module vector_normalizer #(
    parameter int DATAWIDTH   = 16,
    parameter int FRAC_BITS   = 8,
    parameter int NUM_CH      = 4,
    parameter int INSTANCE_ID = 0,
    localparam int ACC_W  = 2 * DATAWIDTH + $clog2(NUM_CH),
    localparam int ROOT_W = (ACC_W + 1) / 2,
    localparam int OUT_W  = FRAC_BITS + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [NUM_CH*DATAWIDTH-1:0] i_data,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [NUM_CH*OUT_W-1:0]     o_data,
    output logic [ROOT_W-1:0]           o_root,
    output logic                        o_zero
);

    typedef enum logic [2:0] {IDLE, SQUARE, SQRT, DIV, DONE} state_t;

    localparam int DW_ALL = NUM_CH * DATAWIDTH;
    localparam int OD_W   = NUM_CH * OUT_W;
    localparam int PAD_W  = 2 * ROOT_W;
    localparam int DREM_W = ROOT_W + 1;
    // INSTANCE_ID is a pure tag; folding it in as zero keeps it referenced
    localparam int CH_W   = $clog2(NUM_CH + 1) + 0 * INSTANCE_ID;
    localparam int STEP_W = $clog2(ROOT_W + OUT_W + 1);

    state_t             state_q;
    logic [DW_ALL-1:0]  data_q;
    logic [PAD_W-1:0]   acc_q;
    logic [ROOT_W+1:0]  srem_q;
    logic [ROOT_W-1:0]  root_q;
    logic [DREM_W-1:0]  drem_q;
    logic [FRAC_BITS-1:0] qcur_q;
    logic [OD_W-1:0]    qvec_q;
    logic [CH_W-1:0]    ch_q;
    logic [STEP_W-1:0]  step_q;
    logic               i_ready_q;
    logic               o_valid_q;
    logic               o_zero_q;
    logic [OD_W-1:0]    o_data_q;
    logic [ROOT_W-1:0]  o_root_q;

    logic [DATAWIDTH-1:0]   x_s;
    logic [2*DATAWIDTH-1:0] sq_s;
    logic [PAD_W-1:0]       acc_d;
    logic [DW_ALL-1:0]      data_rot_s;
    logic [ROOT_W+1:0]      sshift_s;
    logic [ROOT_W+1:0]      strial_s;
    logic [ROOT_W+1:0]      srem_d;
    logic                   sbit_s;
    logic [ROOT_W-1:0]      root_d;
    logic [DREM_W-1:0]      dtrial_s;
    logic [DREM_W-1:0]      drem_d;
    logic                   dbit_s;
    logic [OUT_W-1:0]       word_s;
    logic [OD_W-1:0]        qvec_d;

    // Datapath steps; the current channel always sits in the low slot of data_q
    always_comb begin
        x_s        = data_q[DATAWIDTH-1:0];
        sq_s       = {{DATAWIDTH{1'b0}}, x_s} * {{DATAWIDTH{1'b0}}, x_s};
        acc_d      = acc_q + PAD_W'(sq_s);
        data_rot_s = (data_q >> DATAWIDTH) | (data_q << ((NUM_CH - 1) * DATAWIDTH));

        sshift_s = (srem_q << 2) | {{ROOT_W{1'b0}}, acc_q[PAD_W-1 -: 2]};
        strial_s = {root_q, 2'b01};
        sbit_s   = (sshift_s >= strial_s);
        if (sbit_s) begin
            srem_d = sshift_s - strial_s;
        end else begin
            srem_d = sshift_s;
        end
        root_d = (root_q << 1) | ROOT_W'(sbit_s);

        // First quotient bit has weight 2^FRAC_BITS, so it compares x_k unshifted
        if (step_q == {STEP_W{1'b0}}) begin
            dtrial_s = DREM_W'(x_s);
        end else begin
            dtrial_s = drem_q << 1;
        end
        dbit_s = (dtrial_s >= {1'b0, root_q});
        if (dbit_s) begin
            drem_d = dtrial_s - {1'b0, root_q};
        end else begin
            drem_d = dtrial_s;
        end
        word_s = {qcur_q, dbit_s};
        qvec_d = (qvec_q >> OUT_W) | (OD_W'(word_s) << ((NUM_CH - 1) * OUT_W));
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= {DW_ALL{1'b0}};
            acc_q     <= {PAD_W{1'b0}};
            srem_q    <= {(ROOT_W + 2){1'b0}};
            root_q    <= {ROOT_W{1'b0}};
            drem_q    <= {DREM_W{1'b0}};
            qcur_q    <= {FRAC_BITS{1'b0}};
            qvec_q    <= {OD_W{1'b0}};
            ch_q      <= {CH_W{1'b0}};
            step_q    <= {STEP_W{1'b0}};
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            o_zero_q  <= 1'b0;
            o_data_q  <= {OD_W{1'b0}};
            o_root_q  <= {ROOT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        data_q    <= i_data;
                        acc_q     <= {PAD_W{1'b0}};
                        ch_q      <= {CH_W{1'b0}};
                        i_ready_q <= 1'b0;
                        state_q   <= SQUARE;
                    end
                end
                SQUARE: begin
                    acc_q  <= acc_d;
                    data_q <= data_rot_s;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        ch_q    <= {CH_W{1'b0}};
                        step_q  <= {STEP_W{1'b0}};
                        srem_q  <= {(ROOT_W + 2){1'b0}};
                        root_q  <= {ROOT_W{1'b0}};
                        state_q <= SQRT;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                SQRT: begin
                    // One extra cycle after the last root bit decides zero vs divide
                    if (step_q == STEP_W'(ROOT_W)) begin
                        step_q <= {STEP_W{1'b0}};
                        if (root_q == {ROOT_W{1'b0}}) begin
                            o_data_q  <= {OD_W{1'b0}};
                            o_root_q  <= {ROOT_W{1'b0}};
                            o_zero_q  <= 1'b1;
                            o_valid_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            state_q <= DIV;
                        end
                    end else begin
                        srem_q <= srem_d;
                        root_q <= root_d;
                        acc_q  <= acc_q << 2;
                        step_q <= step_q + 1'b1;
                    end
                end
                DIV: begin
                    drem_q <= drem_d;
                    qcur_q <= word_s[FRAC_BITS-1:0];
                    if (step_q == STEP_W'(FRAC_BITS)) begin
                        qvec_q <= qvec_d;
                        data_q <= data_rot_s;
                        step_q <= {STEP_W{1'b0}};
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            o_data_q  <= qvec_d;
                            o_root_q  <= root_q;
                            o_zero_q  <= 1'b0;
                            o_valid_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid_q <= 1'b0;
                        i_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_root  = o_root_q;
    assign o_zero  = o_zero_q;

endmodule

// File: tb/tb_vector_normalizer.sv
// Self-checking bench for vector_normalizer: directed corner vectors plus
// randomized vectors against an arithmetic reference model.
module tb_vector_normalizer;

    localparam int DW  = 16;
    localparam int FB  = 8;
    localparam int NCH = 4;
    localparam int OW  = FB + 1;
    localparam int RW  = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              o_ready = 1'b0;
    logic [NCH*DW-1:0] i_data = '0;
    logic              i_ready;
    logic              o_valid;
    logic              o_zero;
    logic [NCH*OW-1:0] o_data;
    logic [RW-1:0]     o_root;

    int total = 0;
    int bad   = 0;

    logic [NCH*OW-1:0] prev_data = '0;
    logic [RW-1:0]     prev_root = '0;
    logic              prev_zero = 1'b0;

    vector_normalizer dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_root  (o_root),
        .o_zero  (o_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact sum of squares, integer square root, integer division
    function automatic void model(input logic [NCH*DW-1:0] v, output logic [NCH*OW-1:0] od,
                                  output logic [RW-1:0] root, output logic z, output int lat);
        longint s = 0;
        longint r;
        longint x;
        for (int k = 0; k < NCH; k++) begin
            x = longint'(v[k*DW +: DW]);
            s += x * x;
        end
        r = longint'($sqrt(real'(s)));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        od = '0;
        z  = (r == 0);
        if (!z) begin
            for (int k = 0; k < NCH; k++) begin
                x = longint'(v[k*DW +: DW]);
                od[k*OW +: OW] = OW'((x << FB) / r);
            end
        end
        root = RW'(r);
        lat  = z ? (NCH + RW + 1) : (NCH + RW + NCH * (FB + 1) + 1);
    endfunction

    task automatic run_vec(input string tag, input logic [NCH*DW-1:0] v, input int hold, input bit toggle);
        logic [NCH*OW-1:0] ed;
        logic [RW-1:0]     er;
        logic              ez;
        int                el;
        int                lat;
        model(v, ed, er, ez, el);
        i_data  = v;
        i_valid = 1'b1;
        o_ready = (hold == 0);
        check_eq({tag, "/ready"}, 64'(i_ready), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 200) begin
            if (toggle) begin
                i_data  = {$urandom, $urandom};
                i_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                check_eq({tag, "/old_result"}, {o_zero, o_root, o_data}, {prev_zero, prev_root, prev_data});
            end
        end
        i_valid = 1'b0;
        check_eq({tag, "/latency"}, 64'(lat), 64'(el));
        check_eq({tag, "/data"}, 64'(o_data), 64'(ed));
        check_eq({tag, "/root"}, 64'(o_root), 64'(er));
        check_eq({tag, "/zero"}, 64'(o_zero), 64'(ez));
        for (int c = 0; c < hold; c++) begin
            if (toggle) begin
                i_data  = {$urandom, $urandom};
                i_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            check_eq({tag, "/hold"}, {i_ready, o_valid, o_zero, o_root, o_data}, {1'b0, 1'b1, ez, er, ed});
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, "/handshake"}, {o_valid, i_ready}, 64'b01);
        o_ready   = 1'b0;
        prev_data = ed;
        prev_root = er;
        prev_zero = ez;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*DW-1:0] v;
        logic [DW-1:0]     x;

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", {i_ready, o_valid, o_zero, o_root, o_data}, {1'b1, 1'b0, 1'b0, {RW{1'b0}}, {(NCH*OW){1'b0}}});
        @(negedge clk);
        rst = 1'b1;

        run_vec("three_four", {16'h0000, 16'h0000, 16'h0400, 16'h0300}, 0, 1'b0);
        check_eq("three_four/const_root", 64'(o_root), 64'h500);
        check_eq("three_four/const_data", 64'(o_data), 64'({9'h000, 9'h000, 9'h0CC, 9'h099}));
        run_vec("unit", {16'h0000, 16'h0000, 16'h0100, 16'h0000}, 3, 1'b1);
        run_vec("all_max", {4{16'hFFFF}}, 0, 1'b1);
        check_eq("all_max/const_root", 64'(o_root), 64'd131070);
        check_eq("all_max/const_data", 64'(o_data), 64'({4{9'h080}}));
        run_vec("zero", {(NCH*DW){1'b0}}, 2, 1'b1);
        run_vec("backpressure", {16'h1234, 16'h0042, 16'h7F00, 16'h0001}, 10, 1'b1);

        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < NCH; k++) begin
                x = DW'($urandom) >> $urandom_range(0, 15);
                if ($urandom_range(0, 3) == 0) x = '0;
                v[k*DW +: DW] = x;
            end
            run_vec("random", v, $urandom_range(0, 3), 1'b1);
        end

        // Abort in the middle of the divide phase
        i_data  = {16'h0500, 16'h0600, 16'h0700, 16'h0800};
        i_valid = 1'b1;
        o_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("abort/reset", {i_ready, o_valid, o_zero, o_root, o_data}, {1'b1, 1'b0, 1'b0, {RW{1'b0}}, {(NCH*OW){1'b0}}});
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort/held", {i_ready, o_valid, o_zero, o_root, o_data}, {1'b1, 1'b0, 1'b0, {RW{1'b0}}, {(NCH*OW){1'b0}}});
        @(negedge clk);
        rst       = 1'b1;
        prev_data = '0;
        prev_root = '0;
        prev_zero = 1'b0;
        run_vec("after_abort", {16'h0010, 16'h2000, 16'h0003, 16'h0ABC}, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
